muldiv_seq: RTL and testbench



---
 rtl/calc_pkg.sv | 16 +
 rtl/muldiv_seq.sv | 140 ++++++++++++++
 tb/tb_muldiv_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared calculator types and constants: FSM state encoding, op select codes
// and the default datapath width.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } muldiv_state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned CALC_W = 8;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider that time-shares
// the external add/sub adder. Optional flag outputs: define MULDIV_FLAGS_EN.
module muldiv_seq
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_W,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
`ifdef MULDIV_FLAGS_EN
  output logic             res_zero,
  output logic             res_ovf,
`endif
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_sub,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout
);

  muldiv_state_t state, next_state;

  // acc doubles as the remainder, mq as the quotient, mcand as the divisor
  logic [WIDTH-1:0] acc, mq, mcand;
  logic [WIDTH-1:0] acc_n, mq_n, trial;
  logic [CNT_W-1:0] cnt;
  logic             op_r;
  logic             ge;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    adder_a    = '0;
    adder_b    = '0;
    adder_sub  = 1'b0;
    acc_n      = acc;
    mq_n       = mq;
    trial      = '0;
    ge         = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (op_div == OP_DIV && b == '0) ? DONE : RUN;
      end
      RUN: begin
        if (op_r == OP_DIV) begin
          trial     = {acc[WIDTH-2:0], mq[WIDTH-1]};
          adder_a   = trial;
          adder_b   = mcand;
          adder_sub = 1'b1;
          // a shifted-out remainder MSB means trial >= 2^WIDTH > divisor
          ge        = adder_cout | acc[WIDTH-1];
          acc_n     = ge ? adder_sum : trial;
          mq_n      = {mq[WIDTH-2:0], ge};
        end else begin
          adder_a = acc;
          adder_b = mq[0] ? mcand : '0;
          acc_n   = {adder_cout, adder_sum[WIDTH-1:1]};
          mq_n    = {adder_sum[0], mq[WIDTH-1:1]};
        end
        if (last) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      mq          <= '0;
      mcand       <= '0;
      cnt         <= '0;
      op_r        <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_FLAGS_EN
      res_zero    <= 1'b0;
      res_ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            op_r  <= op_div;
            acc   <= '0;
            mq    <= (op_div == OP_DIV) ? a : b;
            mcand <= (op_div == OP_DIV) ? b : a;
            if (op_div == OP_DIV && b == '0) begin
              result_hi   <= a;
              result_lo   <= '1;
              div_by_zero <= 1'b1;
`ifdef MULDIV_FLAGS_EN
              res_zero    <= 1'b0;
              res_ovf     <= 1'b1;
`endif
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          acc <= acc_n;
          mq  <= mq_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            result_hi <= acc_n;
            result_lo <= mq_n;
`ifdef MULDIV_FLAGS_EN
            res_zero  <= (op_r == OP_DIV) ? (mq_n == '0) : ({acc_n, mq_n} == '0);
            res_ovf   <= (op_r == OP_DIV) ? 1'b0 : (acc_n != '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Table-driven bench for muldiv_seq with a behavioural model of the shared
// add/sub adder; define MULDIV_FLAGS_EN to also check the flag outputs.
module tb_muldiv_seq;
  import calc_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_div = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_hi, result_lo;
  logic [W-1:0] adder_a, adder_b, adder_sum;
  logic         adder_sub, adder_cout;
`ifdef MULDIV_FLAGS_EN
  logic         res_zero, res_ovf;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // external adder: inverts B and injects carry-in on subtract
  assign {adder_cout, adder_sum} = {1'b0, adder_a}
                                 + {1'b0, (adder_sub ? ~adder_b : adder_b)}
                                 + {{W{1'b0}}, adder_sub};

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div),
    .a(a), .b(b), .busy(busy), .done(done),
    .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero),
`ifdef MULDIV_FLAGS_EN
    .res_zero(res_zero), .res_ovf(res_ovf),
`endif
    .adder_a(adder_a), .adder_b(adder_b), .adder_sub(adder_sub),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic         zero;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge; returns cycles from accept edge to done (0 = timeout).
  task automatic issue(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input int glitch_cyc, output int lat);
    lat = 0;
    op_div = op; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == glitch_cyc) begin
        start = 1'b1; op_div = OP_MUL; a = 8'd2; b = 8'd2;
      end
      if (done) begin
        lat = c;
        break;
      end
      chk("busy_running", {31'b0, busy}, 32'd1);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
    chk({tag, "_hi"}, {24'b0, result_hi}, {24'b0, v.hi});
    chk({tag, "_lo"}, {24'b0, result_lo}, {24'b0, v.lo});
    chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, v.dbz});
`ifdef MULDIV_FLAGS_EN
    chk({tag, "_zero"}, {31'b0, res_zero}, {31'b0, v.zero});
    chk({tag, "_ovf"}, {31'b0, res_ovf}, {31'b0, v.ovf});
`endif
  endtask

  initial begin
    int lat;
    vecs[0] = '{OP_MUL, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 1'b0, 1'b0, 9};
    vecs[1] = '{OP_MUL, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 1'b0, 1'b1, 9};
    vecs[2] = '{OP_MUL, 8'd0,   8'd77,  8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9};
    vecs[3] = '{OP_MUL, 8'd100, 8'd3,   8'h01, 8'h2C, 1'b0, 1'b0, 1'b1, 9};
    vecs[4] = '{OP_DIV, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 1'b0, 1'b0, 9};
    vecs[5] = '{OP_DIV, 8'd255, 8'd129, 8'h7E, 8'h01, 1'b0, 1'b0, 1'b0, 9};
    vecs[6] = '{OP_DIV, 8'd5,   8'd200, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 9};
    vecs[7] = '{OP_DIV, 8'd9,   8'd0,   8'h09, 8'hFF, 1'b1, 1'b0, 1'b1, 1};
    vecs[8] = '{OP_DIV, 8'd9,   8'd3,   8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 9};
    vecs[9] = '{OP_MUL, 8'd128, 8'd2,   8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 9};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", {16'b0, result_hi, result_lo}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      @(negedge clk);
      chk("idle_after_done", {30'b0, busy, done}, 32'd0);
      chk("idle_adder", {15'b0, adder_sub, adder_a, adder_b}, 32'd0);
      chk("hold_hi", {24'b0, result_hi}, {24'b0, vecs[i].hi});
      chk("hold_lo", {24'b0, result_lo}, {24'b0, vecs[i].lo});
    end

    // start pulsed mid-operation must be ignored
    issue(OP_MUL, 8'd13, 8'd11, 3, lat);
    check_result("ignore_start", vecs[0], lat);
    @(negedge clk);
    chk("no_restart", {31'b0, busy}, 32'd0);

    // asynchronous abort during cycle N+4
    op_div = OP_MUL; a = 8'd255; b = 8'd255; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_res", {16'b0, result_hi, result_lo}, 32'd0);
    chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("abort_adder", {15'b0, adder_sub, adder_a, adder_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(vecs[4].op, vecs[4].a, vecs[4].b, 0, lat);
    check_result("after_reset", vecs[4], lat);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
